// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Write side of the CPU instruction memory. Consumes a byte stream made of a
// 4-byte little-endian word count N followed by N little-endian 32-bit words,
// and writes each word to consecutive imem addresses starting at 0. The
// pipeline is held in reset until the image is complete, then released after
// RELEASE_DLY cycles.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   When defined, one extra byte c trails the payload; the image is accepted
//   only if (sum of payload bytes + c) mod 256 == 0, otherwise the loader
//   goes to its error state. When undefined, no trailing byte is consumed.
//
// Parameters
//   IMEM_AW      imem word-address width (capacity 2**IMEM_AW words)
//   RELEASE_DLY  cycles spent holding the CPU in reset after the last write (>=1)
//
// Ports
//   clk         clock
//   reset       synchronous, active-low reset
//   in_valid    byte source presents a byte on in_data
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle (depends on state only)
//   imem_we     one-cycle imem write strobe
//   imem_addr   imem word address (holds last value between strobes)
//   imem_wdata  imem write data   (holds last value between strobes)
//   cpu_reset   active-high reset to the pipeline
//   done        image loaded and CPU running (sticky until reset)
//   err         load failed (sticky until reset)
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int IMEM_AW     = 12,
  parameter int RELEASE_DLY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               err
);

  // Word counters need one extra bit so a full-capacity image (N == 2**IMEM_AW)
  // is representable.
  localparam int          CW  = IMEM_AW + 1;
  localparam int          HW  = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [32:0] CAP = 33'd1 << IMEM_AW;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM = 3'd2,
`endif
    S_HOLD = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Where the loader goes once the last payload word (or an empty header)
  // has been taken.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_PAYLOAD_END = S_CSUM;
`else
  localparam state_t S_PAYLOAD_END = S_HOLD;
`endif

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;   // byte position inside the current 4-byte group
  logic [23:0]   asm_q;      // upper three bytes of the group collected so far
  logic [CW-1:0] word_num;   // N from the header
  logic [CW-1:0] word_cnt;   // words written so far
  logic [HW-1:0] hold_cnt;

  logic          accept;
  logic          last_byte;
  logic          last_word;
  logic          hold_done;
  logic [31:0]   word;

  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign last_word = (word_cnt == word_num - CW'(1));
  assign hold_done = (hold_cnt == HW'(RELEASE_DLY - 1));
  // Bytes arrive LSB first: each new byte enters at the top and earlier bytes
  // slide down, so the 4th byte completes the word in place.
  assign word      = {in_data, asm_q};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] csum_tot;
  assign csum_tot = sum_q + in_data;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_HDR;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt is defaulted before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (last_byte) begin
          if ({1'b0, word} > CAP)  state_nxt = S_ERR;
          else if (word == 32'd0)  state_nxt = S_PAYLOAD_END;
          else                     state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte && last_word) state_nxt = S_PAYLOAD_END;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_nxt = (csum_tot == 8'd0) ? S_HOLD : S_ERR;
      end
`endif
      S_HOLD: begin
        if (hold_done) state_nxt = S_RUN;
      end
      S_RUN:   state_nxt = S_RUN;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_HDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure functions of state)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_HDR,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DATA:  in_ready = 1'b1;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte assembly, counters and the registered imem write port.
  // The write strobe is registered, so it appears the cycle after the 4th byte
  // of a word; a reset in that window clears it before it is ever driven.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt   <= '0;
      asm_q      <= '0;
      word_num   <= '0;
      word_cnt   <= '0;
      hold_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= word[31:8];
      end

      // Oversized counts go to ERR, so truncation here only affects values
      // that are never used.
      if (state == S_HDR && last_byte) word_num <= word[CW-1:0];

      if (state == S_DATA && last_byte) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt[IMEM_AW-1:0];
        imem_wdata <= word;
        word_cnt   <= word_cnt + CW'(1);
      end

`ifdef LOADER_CHECKSUM_EN
      if (state == S_DATA && accept) sum_q <= csum_tot;
`endif

      if (state == S_HOLD) hold_cnt <= hold_cnt + HW'(1);
      else                 hold_cnt <= '0;
    end
  end

endmodule
